// File: rtl/multdiv_if.sv
// Handshake and datapath bus between the pipeline, the multiply/divide
// sequencer and the iterative datapaths.
interface multdiv_if;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] dp_op_a;
  logic [31:0] dp_op_b;
  logic [31:0] dp_counter;
  logic        dp_mult_sel;
  logic [31:0] mult_product;
  logic        mult_overflow;
  logic [31:0] div_quotient;
  logic [31:0] result;
  logic        exception;
  logic        result_rdy;
  logic        busy;

  // Sequencer side
  modport slave (
    input  ctrl_mult, ctrl_div, operand_a, operand_b,
           mult_product, mult_overflow, div_quotient,
    output dp_op_a, dp_op_b, dp_counter, dp_mult_sel,
           result, exception, result_rdy, busy
  );

  // Pipeline / datapath side
  modport master (
    output ctrl_mult, ctrl_div, operand_a, operand_b,
           mult_product, mult_overflow, div_quotient,
    input  dp_op_a, dp_op_b, dp_counter, dp_mult_sel,
           result, exception, result_rdy, busy
  );
endinterface

// File: rtl/multdiv_sequencer.sv
// Control unit for the iterative multiply/divide datapaths: latches operands,
// drives the shared step counter and captures the final result.
module multdiv_sequencer #(
  parameter int MULT_STEPS = 16,
  parameter int DIV_STEPS  = 32
) (
  input  logic     clk,
  input  logic     reset,
  multdiv_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam logic [5:0] MULT_LAST = 6'(MULT_STEPS);
  localparam logic [5:0] DIV_LAST  = 6'(DIV_STEPS);

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic [31:0] op_a, op_b;
  logic        mult_sel;
  logic [31:0] res_q;
  logic        exc_q;
  logic        rdy_q;

  logic       start;
  logic [5:0] last;
  logic       div_zero;
  logic       done;

  // Completion detection; a zero divisor finishes one cycle after start
  always_comb begin
    start    = bus.ctrl_mult | bus.ctrl_div;
    last     = (state == S_MULT) ? MULT_LAST : DIV_LAST;
    div_zero = (state == S_DIV) && (op_b == 32'd0);
    done     = (state != S_IDLE) && ((cnt == last) || div_zero);
  end

  // Sequencer state: a start pulse always wins over completion (abort/restart)
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= 6'd0;
      op_a     <= 32'd0;
      op_b     <= 32'd0;
      mult_sel <= 1'b0;
      res_q    <= 32'd0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (start) begin
        op_a     <= bus.operand_a;
        op_b     <= bus.operand_b;
        cnt      <= 6'd0;
        mult_sel <= bus.ctrl_mult;
        state    <= bus.ctrl_mult ? S_MULT : S_DIV;
      end else if (done) begin
        if (state == S_MULT) begin
          res_q <= bus.mult_product;
          exc_q <= bus.mult_overflow;
        end else begin
          res_q <= div_zero ? 32'd0 : bus.div_quotient;
          exc_q <= div_zero;
        end
        rdy_q <= 1'b1;
        state <= S_IDLE;
        cnt   <= 6'd0;
      end else if (state != S_IDLE) begin
        cnt <= cnt + 6'd1;
      end
    end
  end

  assign bus.dp_op_a     = op_a;
  assign bus.dp_op_b     = op_b;
  assign bus.dp_counter  = {26'd0, cnt};
  assign bus.dp_mult_sel = mult_sel;
  assign bus.result      = res_q;
  assign bus.exception   = exc_q;
  assign bus.result_rdy  = rdy_q;
  assign bus.busy        = (state != S_IDLE);
endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer with behavioural datapath stand-ins.
module tb_multdiv_sequencer;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  multdiv_if bus();

  multdiv_sequencer #(.MULT_STEPS(16), .DIV_STEPS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapaths: final values are available combinationally
  logic signed [63:0] full_prod;
  always_comb begin
    full_prod         = $signed(bus.dp_op_a) * $signed(bus.dp_op_b);
    bus.mult_product  = full_prod[31:0];
    bus.mult_overflow = (full_prod[63:31] != {33{1'b0}}) &&
                        (full_prod[63:31] != {33{1'b1}});
    bus.div_quotient  = (bus.dp_op_b == 32'd0) ? 32'd0 :
                        32'($signed(bus.dp_op_a) / $signed(bus.dp_op_b));
  end

  // Called at a negedge; leaves the bench at the negedge of cycle 0
  task automatic start(input logic mult, input logic [31:0] a, input logic [31:0] b);
    bus.ctrl_mult = mult;
    bus.ctrl_div  = ~mult;
    bus.operand_a = a;
    bus.operand_b = b;
    @(negedge clk);
    bus.ctrl_mult = 1'b0;
    bus.ctrl_div  = 1'b0;
    bus.operand_a = 32'hDEAD_BEEF;
    bus.operand_b = 32'hDEAD_BEEF;
  endtask

  // Observe n cycles; report first cycle with result_rdy and count of pulses
  task automatic watch(input int n, output int first, output int cnt,
                       output logic [31:0] res, output logic exc);
    first = 0; cnt = 0; res = 32'hX; exc = 1'bx;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (bus.result_rdy === 1'b1) begin
        cnt++;
        if (first == 0) begin
          first = i; res = bus.result; exc = bus.exception;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.dp_op_a, bus.dp_op_b, bus.dp_counter, bus.result} !== 128'd0 ||
        {bus.exception, bus.result_rdy, bus.busy, bus.dp_mult_sel} !== 4'b0) begin
      bad++;
      $display("FAIL reset_state: a=%h b=%h cnt=%h res=%h exc/rdy/busy/sel=%b%b%b%b required all 0",
               bus.dp_op_a, bus.dp_op_b, bus.dp_counter, bus.result,
               bus.exception, bus.result_rdy, bus.busy, bus.dp_mult_sel);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult_basic();
    int f, c; logic [31:0] r; logic e;
    start(1'b1, 32'd7, -32'sd3);
    total++;
    if (bus.dp_counter !== 32'd0 || bus.dp_mult_sel !== 1'b1 || bus.busy !== 1'b1 ||
        bus.dp_op_a !== 32'd7 || bus.dp_op_b !== 32'hFFFF_FFFD) begin
      bad++;
      $display("FAIL mult_cycle0: cnt=%0d sel=%b busy=%b a=%h b=%h required 0 1 1 7 fffffffd",
               bus.dp_counter, bus.dp_mult_sel, bus.busy, bus.dp_op_a, bus.dp_op_b);
    end
    @(negedge clk);
    total++;
    if (bus.dp_counter !== 32'd1) begin
      bad++; $display("FAIL mult_cycle1_counter: got %0d required 1", bus.dp_counter);
    end
    watch(24, f, c, r, e);
    total++;
    // watch started at cycle 1, so cycle index = f + 1
    if (c !== 1 || f + 1 !== 17) begin
      bad++; $display("FAIL mult_rdy_timing: pulses=%0d cycle=%0d required 1 at 17", c, f + 1);
    end
    total++;
    if (r !== 32'hFFFF_FFEB || e !== 1'b0) begin
      bad++; $display("FAIL mult_result: got %h exc=%b required ffffffeb 0", r, e);
    end
    total++;
    if (bus.busy !== 1'b0 || bus.dp_counter !== 32'd0 || bus.result !== 32'hFFFF_FFEB ||
        bus.dp_op_a !== 32'd7 || bus.dp_mult_sel !== 1'b1) begin
      bad++;
      $display("FAIL mult_idle_hold: busy=%b cnt=%0d res=%h a=%h sel=%b required 0 0 ffffffeb 7 1",
               bus.busy, bus.dp_counter, bus.result, bus.dp_op_a, bus.dp_mult_sel);
    end
  endtask

  task automatic test_mult_overflow();
    int f, c; logic [31:0] r; logic e;
    start(1'b1, 32'h7FFF_FFFF, 32'd2);
    watch(22, f, c, r, e);
    total++;
    if (c !== 1 || f !== 17 || e !== 1'b1 || r !== 32'hFFFF_FFFE) begin
      bad++;
      $display("FAIL mult_overflow: pulses=%0d cycle=%0d exc=%b res=%h required 1 17 1 fffffffe",
               c, f, e, r);
    end
  endtask

  task automatic test_div_basic();
    int f, c; logic [31:0] r; logic e;
    start(1'b0, 32'd100, 32'd7);
    total++;
    if (bus.dp_mult_sel !== 1'b0 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL div_cycle0: sel=%b busy=%b required 0 1", bus.dp_mult_sel, bus.busy);
    end
    watch(32, f, c, r, e);
    total++;
    if (c !== 0 || bus.dp_counter !== 32'd32 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL div_cycle32: pulses=%0d cnt=%0d busy=%b required 0 32 1",
               c, bus.dp_counter, bus.busy);
    end
    @(negedge clk);
    total++;
    if (bus.result_rdy !== 1'b1 || bus.result !== 32'd14 || bus.exception !== 1'b0 ||
        bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL div_cycle33: rdy=%b res=%0d exc=%b busy=%b required 1 14 0 0",
               bus.result_rdy, bus.result, bus.exception, bus.busy);
    end
    @(negedge clk);
    total++;
    if (bus.result_rdy !== 1'b0 || bus.result !== 32'd14) begin
      bad++; $display("FAIL div_rdy_one_cycle: rdy=%b res=%0d required 0 14", bus.result_rdy, bus.result);
    end
  endtask

  task automatic test_div_zero();
    start(1'b0, 32'd55, 32'd0);
    @(negedge clk);
    total++;
    if (bus.result_rdy !== 1'b1 || bus.result !== 32'd0 || bus.exception !== 1'b1 ||
        bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL div_zero: rdy=%b res=%h exc=%b busy=%b required 1 0 1 0",
               bus.result_rdy, bus.result, bus.exception, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int f, c; logic [31:0] r; logic e;
    start(1'b1, 32'd5, 32'd6);
    watch(4, f, c, r, e);
    start(1'b0, 32'd9, 32'd3);  // sampled at edge 5 of the multiply
    watch(40, f, c, r, e);
    total++;
    // div started at edge 5; rdy at div cycle 33 == mult cycle 38
    if (c !== 1 || f + 5 !== 38 || r !== 32'd3 || e !== 1'b0) begin
      bad++;
      $display("FAIL back_to_back: pulses=%0d cycle=%0d res=%0d exc=%b required 1 38 3 0",
               c, f + 5, r, e);
    end
  endtask

  task automatic test_restart_on_done();
    int f, c; logic [31:0] r; logic e;
    logic [31:0] prev;
    prev = bus.result;
    start(1'b1, 32'd4, 32'd4);
    watch(15, f, c, r, e);      // now at cycle 15; next edge 16 is the completing edge... edge 17
    @(negedge clk);             // cycle 16, counter==16
    start(1'b0, 32'd20, 32'd4); // start sampled on completing edge 17
    total++;
    if (bus.result_rdy !== 1'b0 || bus.result !== prev || bus.dp_counter !== 32'd0 ||
        bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL restart_on_done: rdy=%b res=%h cnt=%0d busy=%b required 0 %h 0 1",
               bus.result_rdy, bus.result, bus.dp_counter, bus.busy, prev);
    end
    watch(36, f, c, r, e);
    total++;
    if (c !== 1 || f !== 33 || r !== 32'd5) begin
      bad++; $display("FAIL restart_result: pulses=%0d cycle=%0d res=%0d required 1 33 5", c, f, r);
    end
  endtask

  task automatic test_reset_mid_op();
    int f, c; logic [31:0] r; logic e;
    start(1'b1, 32'd3, 32'd3);
    watch(9, f, c, r, e);
    reset = 1'b1;               // sampled at edge 10
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (bus.busy !== 1'b0 || bus.result !== 32'd0 || bus.exception !== 1'b0 ||
        bus.dp_counter !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid_op: busy=%b res=%h exc=%b cnt=%0d required 0 0 0 0",
               bus.busy, bus.result, bus.exception, bus.dp_counter);
    end
    watch(25, f, c, r, e);
    total++;
    if (c !== 0) begin
      bad++; $display("FAIL reset_no_rdy: pulses=%0d required 0", c);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1;
    bus.ctrl_mult = 1'b0; bus.ctrl_div = 1'b0;
    bus.operand_a = 32'd0; bus.operand_b = 32'd0;
    @(negedge clk);
    test_reset();
    test_mult_basic();
    test_mult_overflow();
    test_div_basic();
    test_div_zero();
    test_back_to_back();
    test_restart_on_done();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
